// File: rtl/first_stage_vector_streamer_if.sv
// Bus bundle between the first-stage vector streamer, its weight memory and
// the first-stage quadrant MAC receivers.
//
// Handshake: b_element_ready is a pure valid strobe. The receivers have no
// ready/backpressure path and must take b_element on every cycle where
// b_element_ready=1. last_element and layer qualify the same beat. A memory
// read is requested by mem_read/mem_addr in cycle t, and mem_data must be
// valid in cycle t+1.
interface first_stage_vector_streamer_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic signed [15:0]    mem_data;
    logic signed [15:0]    b_element;
    logic                  b_element_ready;
    logic                  last_element;
    logic [1:0]            layer;

    // Streamer side
    modport master (
        output mem_read, mem_addr,
        input  mem_data,
        output b_element, b_element_ready, last_element, layer
    );

    // Memory and receiver side
    modport slave (
        input  mem_read, mem_addr,
        output mem_data,
        input  b_element, b_element_ready, last_element, layer
    );
endinterface

// File: rtl/first_stage_vector_streamer.sv
// Transmit side of the first-stage element stream. It reads LAYERS vectors of
// VECTOR_LENGTH signed elements from a synchronous weight memory and presents
// them to the receivers one per cycle, two cycles after each read is issued.
// Vectors are separated by at least GAP_CYCLES idle cycles. A vector is never
// split, because the receivers clear their accumulators on any idle cycle.
module first_stage_vector_streamer #(
    parameter int VECTOR_LENGTH = 16,
    parameter int LAYERS        = 4,
    parameter int ADDR_WIDTH    = 8,
    parameter int BASE_ADDR     = 0,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       go,
    input  logic       hold,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state,
    first_stage_vector_streamer_if.master bus
);

    localparam int IDX_W = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(VECTOR_LENGTH - 1);
    localparam logic [1:0]       LAST_LAYER = 2'(LAYERS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [1:0]            layer_q;
    logic [GAP_W-1:0]      gap_q;
    logic                  rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  busy_q;
    logic                  done_q;

    // Read-return stage: tags travelling with the read issued last cycle
    logic                  rd_v_q;
    logic                  rd_last_q;
    logic [1:0]            rd_layer_q;

    // Presentation stage
    logic                  elem_ready_q;
    logic signed [15:0]    elem_q;
    logic                  elem_last_q;
    logic [1:0]            elem_layer_q;

    // Sequencer: issues one read per cycle per vector, inserts the inter-vector gap,
    // then waits for the final element to be presented before pulsing done.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            idx_q   <= '0;
            layer_q <= '0;
            gap_q   <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // go coinciding with the done pulse belongs to the finished run
                    if (go && !done_q) begin
                        state_q <= ISSUE;
                        idx_q   <= '0;
                        layer_q <= '0;
                        rd_q    <= 1'b1;
                        addr_q  <= ADDR_WIDTH'(BASE_ADDR);
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Layers are stored back to back, so the address simply runs on
                    addr_q <= addr_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        rd_q    <= 1'b0;
                        idx_q   <= '0;
                        gap_q   <= '0;
                        state_q <= (layer_q == LAST_LAYER) ? DRAIN : GAP;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                GAP: begin
                    // Minimum gap first; hold only extends it once the minimum is met
                    if (gap_q == GAP_LAST) begin
                        if (!hold) begin
                            state_q <= ISSUE;
                            rd_q    <= 1'b1;
                            layer_q <= layer_q + 2'd1;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Only the final element of the run is presented with last in DRAIN
                    if (elem_ready_q && elem_last_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-stage return path: tag the read, then register memory data onto the stream.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            rd_v_q       <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_layer_q   <= '0;
            elem_ready_q <= 1'b0;
            elem_q       <= '0;
            elem_last_q  <= 1'b0;
            elem_layer_q <= '0;
        end else begin
            rd_v_q       <= rd_q;
            rd_last_q    <= rd_q && (idx_q == LAST_IDX);
            rd_layer_q   <= layer_q;
            elem_ready_q <= rd_v_q;
            elem_q       <= rd_v_q ? bus.mem_data : 16'sd0;
            elem_last_q  <= rd_v_q && rd_last_q;
            // layer only moves when an element is actually presented
            if (rd_v_q) begin
                elem_layer_q <= rd_layer_q;
            end
        end
    end

    assign bus.mem_read        = rd_q;
    assign bus.mem_addr        = addr_q;
    assign bus.b_element       = elem_q;
    assign bus.b_element_ready = elem_ready_q;
    assign bus.last_element    = elem_last_q;
    assign bus.layer           = elem_layer_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_first_stage_vector_streamer.sv
// Bench for first_stage_vector_streamer: a default instance (16 x 4) and a
// single-element-vector instance (1 x 4), each with its own synchronous memory.
module tb_first_stage_vector_streamer;

    localparam int VL   = 16;
    localparam int NL   = 4;
    localparam int GAP  = 1;
    localparam int AW   = 8;
    localparam int BASE = 0;
    localparam int A    = 1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic clear = 1'b1;
    logic go    = 1'b0;
    logic hold  = 1'b0;
    logic go1   = 1'b0;
    logic busy0, done0, busy1, done1;
    logic [1:0] st0, st1;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    first_stage_vector_streamer_if #(.ADDR_WIDTH(AW)) bus0 ();
    first_stage_vector_streamer_if #(.ADDR_WIDTH(AW)) bus1 ();

    first_stage_vector_streamer #(
        .VECTOR_LENGTH(VL), .LAYERS(NL), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .GAP_CYCLES(GAP)
    ) dut (
        .clock(clock), .clear(clear), .go(go), .hold(hold),
        .busy(busy0), .done(done0), .dbg_state(st0), .bus(bus0)
    );

    first_stage_vector_streamer #(
        .VECTOR_LENGTH(1), .LAYERS(NL), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .GAP_CYCLES(GAP)
    ) dut1 (
        .clock(clock), .clear(clear), .go(go1), .hold(1'b0),
        .busy(busy1), .done(done1), .dbg_state(st1), .bus(bus1)
    );

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];

    always @(posedge clock) if (bus0.mem_read) bus0.mem_data <= mem0[bus0.mem_addr];
    always @(posedge clock) if (bus1.mem_read) bus1.mem_data <= mem1[bus1.mem_addr];

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [34:0] exp_q[$];
    logic [34:0] exp1_q[$];
    logic [7:0]  exp_addr_q[$];
    int go_cyc = 1 << 30, exp_done = 0, run_done = 0, elem_seen = 0;
    int go1_cyc = 1 << 30, exp_done1 = 0, run_done1 = 0;
    bit recv_on = 1'b0;
    int acc = 0, zv = 0, recv_pulses = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected beat: presentation cycle, layer, last flag, element value
    function automatic logic [34:0] pk(input int c, input logic [1:0] l, input logic last,
                                       input logic [15:0] d);
        return {c[15:0], l, last, d};
    endfunction

    // Default instance monitor, with a behavioural quadrant receiver (z = sum a*b per vector)
    always @(negedge clock) begin
        logic [35:0] e;
        logic [8:0]  ea;
        check_val("busy", busy0, (cyc > go_cyc) && (cyc < exp_done));
        if (done0) begin
            check_val("done_cyc", cyc, exp_done);
            run_done++;
        end
        if (bus0.mem_read) begin
            ea = (exp_addr_q.size() != 0) ? {1'b0, exp_addr_q.pop_front()} : 9'h1FF;
            check_val("addr", {1'b0, bus0.mem_addr}, ea);
        end
        if (bus0.b_element_ready) begin
            elem_seen++;
            e = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : '1;
            check_val("elem", {1'b0, pk(cyc, bus0.layer, bus0.last_element, bus0.b_element)}, e);
            zv = acc + A * int'($signed(bus0.b_element));
            if (bus0.last_element) begin
                if (recv_on) begin
                    check_val("z_element", zv, 16);
                    recv_pulses++;
                end
                acc = 0;
            end else begin
                acc = zv;
            end
        end else begin
            check_val("idle_zero", {bus0.last_element, bus0.b_element}, 0);
            acc = 0;
        end
    end

    // Single-element-vector instance monitor
    always @(negedge clock) begin
        logic [35:0] e;
        check_val("busy1", busy1, (cyc > go1_cyc) && (cyc < exp_done1));
        if (done1) begin
            check_val("done1_cyc", cyc, exp_done1);
            run_done1++;
        end
        if (bus1.b_element_ready) begin
            e = (exp1_q.size() != 0) ? {1'b0, exp1_q.pop_front()} : '1;
            check_val("elem1", {1'b0, pk(cyc, bus1.layer, bus1.last_element, bus1.b_element)}, e);
        end else begin
            check_val("idle_zero1", {bus1.last_element, bus1.b_element}, 0);
        end
    end

    // ---------------- driver tasks ----------------
    // One run on the default instance. hold_len: hold cycles from the start of the
    // first gap. abort_after: assert clear once that many elements were seen (0 = never).
    // rep_go: relative cycle at which go is pulsed again (-1 = never).
    task automatic start_run(input int hold_len, input int abort_after, input int rep_go,
                             input bit go_at_done);
        int g, extra, hs, c, rel;
        @(negedge clock);
        g     = cyc;
        extra = (hold_len >= GAP) ? hold_len - GAP + 1 : 0;
        hs    = 1 + VL;
        c     = g;
        for (int l = 0; l < NL; l++) begin
            for (int i = 0; i < VL; i++) begin
                c = g + 3 + l * (VL + GAP) + ((l > 0) ? extra : 0) + i;
                exp_q.push_back(pk(c, 2'(l), (i == VL - 1), mem0[8'(BASE + l * VL + i)]));
                exp_addr_q.push_back(8'(BASE + l * VL + i));
            end
        end
        exp_done  = c + 1;
        go_cyc    = g;
        run_done  = 0;
        elem_seen = 0;
        go        = 1'b1;
        for (int k = 1; k <= exp_done - g + 12; k++) begin
            @(negedge clock);
            rel  = cyc - g;
            go   = (rel == rep_go) || (go_at_done && (cyc == exp_done));
            hold = (rel >= hs) && (rel < hs + hold_len);
            if (abort_after > 0 && elem_seen >= abort_after) begin
                go   = 1'b0;
                hold = 1'b0;
                #2 clear = 1'b1;
                #1 check_val("clear_outputs",
                             {bus0.b_element_ready, bus0.b_element, bus0.last_element, bus0.layer,
                              bus0.mem_read, bus0.mem_addr, busy0, done0, st0}, 0);
                exp_q.delete();
                exp_addr_q.delete();
                go_cyc   = 1 << 30;
                exp_done = 0;
                @(negedge clock);
                clear = 1'b0;
                repeat (10) @(negedge clock);
                return;
            end
        end
        go   = 1'b0;
        hold = 1'b0;
        check_val("done_count", run_done, 1);
        check_val("elems_left", exp_q.size(), 0);
    endtask

    task automatic run_single;
        int g;
        @(negedge clock);
        g = cyc;
        for (int l = 0; l < NL; l++)
            exp1_q.push_back(pk(g + 3 + l * (1 + GAP), 2'(l), 1'b1, mem1[8'(BASE + l)]));
        exp_done1 = g + 3 + (NL - 1) * (1 + GAP) + 1;
        go1_cyc   = g;
        run_done1 = 0;
        go1       = 1'b1;
        repeat (exp_done1 - g + 6) begin
            @(negedge clock);
            go1 = 1'b0;
        end
        check_val("done1_count", run_done1, 1);
        check_val("elems1_left", exp1_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int k = 0; k < 256; k++) begin
            mem0[k] = 16'(k + 1);
            mem1[k] = 16'($urandom);
        end
        repeat (3) @(negedge clock);
        check_val("reset_outputs",
                  {bus0.b_element_ready, bus0.b_element, bus0.last_element, bus0.layer,
                   bus0.mem_read, bus0.mem_addr, busy0, done0, st0}, 0);
        clear = 1'b0;
        repeat (2) @(negedge clock);

        // counting pattern, no hold
        start_run(0, 0, -1, 1'b0);

        // random data, hold 5 cycles in the first gap
        for (int k = 0; k < 256; k++) mem0[k] = 16'($urandom);
        start_run(5, 0, -1, 1'b0);

        // random data, random hold length
        for (int k = 0; k < 256; k++) mem0[k] = 16'($urandom);
        start_run($urandom_range(1, 6), 0, -1, 1'b0);

        // asynchronous clear mid-vector, then a clean restart
        start_run(0, 7, -1, 1'b0);
        start_run(0, 0, -1, 1'b0);

        // go re-pulsed while busy and in the done cycle
        for (int k = 0; k < 256; k++) mem0[k] = 16'($urandom);
        start_run(0, 0, $urandom_range(1, 60), 1'b1);

        // single-element vectors
        run_single();

        // behavioural receiver against an all-ones memory
        for (int k = 0; k < 256; k++) mem0[k] = 16'd1;
        recv_on     = 1'b1;
        recv_pulses = 0;
        start_run(0, 0, -1, 1'b0);
        check_val("z_pulses", recv_pulses, NL);
        recv_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
